// File: rtl/simple_risc_pkg.sv
// simple_risc_pkg: shared widths, control bit map, rd field position and the EX->MA bundle type.
package simple_risc_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;
  localparam int CTRL_ISLD  = 0;
  localparam int CTRL_ISST  = 1;
  localparam int CTRL_ISWB  = 2;
  localparam int CTRL_ISCALL = 3;
  localparam int CTRL_ISRET = 4;
  localparam int CTRL_ISMUL = 5;
  localparam int CTRL_ISBEQ = 6;
  localparam int CTRL_ISUBR = 7;
  localparam int RD_HI = 25;
  localparam int RD_LO = 22;
  typedef struct packed {
    logic [DEF_DATA_W-1:0] pc;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_DATA_W-1:0] op2;
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_CTRL_W-1:0] ctrl;
  } ex_ma_bundle_t;
endpackage

// File: rtl/ex_ma_slot.sv
// ex_ma_slot: one valid bit plus payload; payload only moves on load so idle slots stay quiet.
module ex_ma_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_q     <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_q     <= i_d;
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/ex_ma_latch.sv
// ex_ma_latch: EX->MA pipeline register with 2-entry skid so exReady is a pure flop.
// EX_MA_FWD_EN adds the fwdValid/fwdRd/fwdData bypass outputs.
module ex_ma_latch
  import simple_risc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exValid,
  output logic              exReady,
  input  logic [DATA_W-1:0] exPc,
  input  logic [DATA_W-1:0] exAluResult,
  input  logic [DATA_W-1:0] exOp2,
  input  logic [DATA_W-1:0] exInstr,
  input  logic [CTRL_W-1:0] exCtrl,
  input  logic              flush,
  output logic              maValid,
  input  logic              maReady,
  output logic [DATA_W-1:0] maPc,
  output logic [DATA_W-1:0] maAluResult,
  output logic [DATA_W-1:0] maOp2,
  output logic [DATA_W-1:0] maInstr,
`ifdef EX_MA_FWD_EN
  output logic [CTRL_W-1:0] maCtrl,
  output logic              fwdValid,
  output logic [3:0]        fwdRd,
  output logic [DATA_W-1:0] fwdData
`else
  output logic [CTRL_W-1:0] maCtrl
`endif
);
  localparam int BW = 4 * DATA_W + CTRL_W;
  logic          r_ex_ready;
  logic          w_main_v, w_skid_v, w_accept, w_pop, w_from_skid;
  logic          w_main_load, w_main_clr, w_skid_load, w_skid_clr, w_skid_v_nxt;
  logic [BW-1:0] w_ex_d, w_main_d, w_main_q, w_skid_q;
  assign w_ex_d      = {exPc, exAluResult, exOp2, exInstr, exCtrl};
  assign w_accept    = exValid && r_ex_ready;
  assign w_pop       = w_main_v && maReady;
  assign w_from_skid = w_pop && w_skid_v;
  // accept lands in main when main is free or draining with nothing queued behind it
  assign w_main_load = !flush && ((w_accept && (!w_main_v || (w_pop && !w_skid_v))) || w_from_skid);
  assign w_main_clr  = flush || (w_pop && !w_skid_v);
  assign w_skid_load = !flush && w_accept && w_main_v && !w_pop;
  assign w_skid_clr  = flush || w_from_skid;
  assign w_skid_v_nxt = w_skid_load || (w_skid_v && !w_skid_clr);
  assign w_main_d    = w_from_skid ? w_skid_q : w_ex_d;
  always_ff @(posedge clk) begin
    if (reset) r_ex_ready <= 1'b1;
    else r_ex_ready <= !w_skid_v_nxt;
  end
  ex_ma_slot #(.W(BW)) u_main (
    .clk(clk), .rst(reset), .i_load(w_main_load), .i_clear(w_main_clr),
    .i_d(w_main_d), .o_valid(w_main_v), .o_q(w_main_q)
  );
  ex_ma_slot #(.W(BW)) u_skid (
    .clk(clk), .rst(reset), .i_load(w_skid_load), .i_clear(w_skid_clr),
    .i_d(w_ex_d), .o_valid(w_skid_v), .o_q(w_skid_q)
  );
  assign exReady = r_ex_ready;
  assign maValid = w_main_v;
  assign {maPc, maAluResult, maOp2, maInstr, maCtrl} = w_main_q;
`ifdef EX_MA_FWD_EN
  assign fwdValid = w_main_v && maCtrl[CTRL_ISWB] && !maCtrl[CTRL_ISLD];
  assign fwdRd    = maInstr[RD_HI:RD_LO];
  assign fwdData  = maAluResult;
`endif
endmodule

// File: tb/tb_ex_ma_latch.sv
// tb_ex_ma_latch: directed + random traffic, scoreboard queue checked by a negedge monitor.
module tb_ex_ma_latch;
  import simple_risc_pkg::*;
  logic        clk = 1'b0;
  logic        reset, exValid, exReady, flush, maValid, maReady;
  logic [31:0] exPc, exAluResult, exOp2, exInstr, maPc, maAluResult, maOp2, maInstr;
  logic [7:0]  exCtrl, maCtrl;
`ifdef EX_MA_FWD_EN
  logic        fwdValid;
  logic [3:0]  fwdRd;
  logic [31:0] fwdData;
`endif
  int n_cmp = 0;
  int n_err = 0;
  ex_ma_bundle_t sb[$];
  ex_ma_bundle_t prev_b, cur_b, exp_b;
  bit prev_hold = 1'b0;
  always #5 clk = ~clk;
  ex_ma_latch dut (
    .clk(clk), .reset(reset), .exValid(exValid), .exReady(exReady),
    .exPc(exPc), .exAluResult(exAluResult), .exOp2(exOp2), .exInstr(exInstr), .exCtrl(exCtrl),
    .flush(flush), .maValid(maValid), .maReady(maReady),
    .maPc(maPc), .maAluResult(maAluResult), .maOp2(maOp2), .maInstr(maInstr),
`ifdef EX_MA_FWD_EN
    .maCtrl(maCtrl), .fwdValid(fwdValid), .fwdRd(fwdRd), .fwdData(fwdData)
`else
    .maCtrl(maCtrl)
`endif
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] alu);
    exValid = v;
    exAluResult = alu;
    exPc = 32'h1000 + {alu[29:0], 2'b00};
    exOp2 = ~alu;
    exInstr = {6'h0, alu[3:0], 22'h0};
    exCtrl = 8'h24;
  endtask
  // monitor: check pops against scoreboard, stability while stalled, then record accepts
  always @(negedge clk) begin
    cur_b = '{maPc, maAluResult, maOp2, maInstr, maCtrl};
    if (prev_hold) begin
      check("hold_valid", {31'b0, maValid}, 32'd1);
      n_cmp++;
      if (cur_b !== prev_b) begin
        n_err++;
        $display("FAIL hold_stable: got %h expected %h", cur_b, prev_b);
      end
    end
`ifdef EX_MA_FWD_EN
    if (maValid && sb.size() > 0 && !reset) begin
      check("fwd_rd", {28'b0, fwdRd}, {28'b0, sb[0].instr[25:22]});
      check("fwd_valid", {31'b0, fwdValid}, {31'b0, sb[0].ctrl[CTRL_ISWB] && !sb[0].ctrl[CTRL_ISLD]});
    end else if (!maValid) check("fwd_idle", {31'b0, fwdValid}, 32'd0);
`endif
    if (maValid && maReady && !flush && !reset) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL pop_underflow: got %h expected none", cur_b);
      end else begin
        exp_b = sb.pop_front();
        if (cur_b !== exp_b) begin
          n_err++;
          $display("FAIL pop_data: got %h expected %h", cur_b, exp_b);
        end
      end
    end
    if (exValid && exReady && !flush && !reset)
      sb.push_back('{exPc, exAluResult, exOp2, exInstr, exCtrl});
    if (flush || reset) sb.delete();
    prev_hold = maValid && !maReady && !flush && !reset;
    prev_b = cur_b;
  end
  initial begin
    reset = 1'b1; flush = 1'b0; maReady = 1'b0;
    drive(1'b1, 32'h55);
    repeat (3) tick();
    check("rst_mavalid", {31'b0, maValid}, 32'd0);
    check("rst_alu", maAluResult, 32'd0);
    check("rst_exready", {31'b0, exReady}, 32'd1);
    reset = 1'b0; drive(1'b0, 32'h0);
    tick();
    check("post_rst_exready", {31'b0, exReady}, 32'd1);
    check("post_rst_mavalid", {31'b0, maValid}, 32'd0);
    // single mul result 5*7
    maReady = 1'b1;
    drive(1'b1, 32'h0000_0023);
    tick();
    drive(1'b0, 32'h0);
    check("single_valid", {31'b0, maValid}, 32'd1);
    check("single_alu", maAluResult, 32'h23);
    tick();
    check("single_gone", {31'b0, maValid}, 32'd0);
    // streaming 1/clk
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i);
      tick();
      check("stream_ready", {31'b0, exReady}, 32'd1);
      check("stream_valid", {31'b0, maValid}, 32'd1);
      check("stream_alu", maAluResult, i);
    end
    drive(1'b0, 32'h0);
    tick();
    check("stream_empty", {31'b0, maValid}, 32'd0);
    // skid fill then drain
    maReady = 1'b0;
    drive(1'b1, 32'hFFFE_0001);
    tick();
    check("skid_ready1", {31'b0, exReady}, 32'd1);
    drive(1'b1, 32'h6);
    tick();
    drive(1'b0, 32'h0);
    check("skid_ready0", {31'b0, exReady}, 32'd0);
    check("skid_head", maAluResult, 32'hFFFE_0001);
    maReady = 1'b1;
    tick();
    check("skid_ready_back", {31'b0, exReady}, 32'd1);
    check("skid_second", maAluResult, 32'h6);
    check("skid_second_v", {31'b0, maValid}, 32'd1);
    tick();
    check("skid_drained", {31'b0, maValid}, 32'd0);
    // flush with both slots full
    maReady = 1'b0;
    drive(1'b1, 32'hA);
    tick();
    drive(1'b1, 32'hB);
    tick();
    check("pre_flush_full", {31'b0, exReady}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'hC);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    check("flush_mavalid", {31'b0, maValid}, 32'd0);
    check("flush_exready", {31'b0, exReady}, 32'd1);
    maReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_nothing", {31'b0, maValid}, 32'd0);
    end
    // random traffic
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom);
      exInstr = $urandom;
      exCtrl = 8'($urandom);
      maReady = $urandom_range(0, 3) != 0;
      tick();
    end
    drive(1'b0, 32'h0);
    maReady = 1'b1;
    repeat (4) tick();
    check("drain_empty", {31'b0, maValid}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
